// File: rtl/debounce_pkg.sv
// Shared types and default constants for the input debounce block.
// The qualifier FSM state encoding lives here so any observer decodes it the same way.
package debounce_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 3;
    localparam int GLITCH_W_DEF        = 8;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    // True while a level change is being qualified.
    function automatic logic is_pending(input state_t st);
        return (st == PEND_HI) || (st == PEND_LO);
    endfunction

    // Smallest counter width that can hold the value n.
    function automatic int min_width(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop level synchronizer for an asynchronous input; all stages clear to 0 on reset.
// The output is the last stage, so a change on d appears on q N edges after it is first sampled.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            stages_reg <= '0;
        end else begin
            stages_reg[0] <= d;
        end
    end

    // Remaining stages simply shift the sampled value down the chain.
    genvar gi;
    generate
        for (gi = 1; gi < N; gi++) begin : g_stage
            always_ff @(posedge clock) begin
                if (reset) begin
                    stages_reg[gi] <= 1'b0;
                end else begin
                    stages_reg[gi] <= stages_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stages_reg[N-1];

endmodule

// File: rtl/input_debounce.sv
// Debounces a raw asynchronous level into x_out with registered rise/fall pulses,
// counting every rejected transition in a saturating glitch counter.
module input_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int GLITCH_W        = GLITCH_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                raw_in,
    input  logic                glitch_clr,
    output logic                x_out,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("input_debounce: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
            $error("input_debounce: DEBOUNCE_CYCLES must be >= 2");
        end
        if (CNT_W < min_width(DEBOUNCE_CYCLES - 1)) begin : g_bad_cnt
            $error("input_debounce: CNT_W too small for DEBOUNCE_CYCLES");
        end
    endgenerate

    logic   s;
    state_t state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic   glitch_event;
    logic   glitch_full;

    sync_chain #(
        .N(SYNC_STAGES)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (raw_in),
        .q    (s)
    );

    // A pending change that reverts before qualification is a glitch.
    assign glitch_event = is_pending(state_reg) &&
                          (((state_reg == PEND_HI) && !s) ||
                           ((state_reg == PEND_LO) &&  s));
    assign glitch_full  = &glitch_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= STABLE_LO;
            cnt_reg   <= '0;
            x_out     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state_reg)
                STABLE_LO: begin
                    if (s) begin
                        state_reg <= PEND_HI;
                        cnt_reg   <= CNT_ONE;
                    end
                end
                PEND_HI: begin
                    if (!s) begin
                        state_reg <= STABLE_LO;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= STABLE_HI;
                        cnt_reg   <= '0;
                        x_out     <= 1'b1;
                        rise      <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_reg <= PEND_LO;
                        cnt_reg   <= CNT_ONE;
                    end
                end
                PEND_LO: begin
                    if (s) begin
                        state_reg <= STABLE_HI;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= STABLE_LO;
                        cnt_reg   <= '0;
                        x_out     <= 1'b0;
                        fall      <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= STABLE_LO;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Clear takes priority over a same-edge increment.
    always_ff @(posedge clock) begin
        if (reset || glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_event && !glitch_full) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: a fixed vector table, directed corner sequences,
// and randomized bouncing input checked against a sample-history reference model.
module tb_input_debounce;

    localparam int N_SYNC = 2;
    localparam int N_DEB  = 4;
    localparam int GMAX   = 255;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       raw_in = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       x_out, rise, fall;
    logic [7:0] glitch_cnt;

    int checks = 0;
    int fails  = 0;

    input_debounce #(
        .SYNC_STAGES(N_SYNC), .DEBOUNCE_CYCLES(N_DEB), .CNT_W(3), .GLITCH_W(8)
    ) dut (
        .clock(clock), .reset(reset), .raw_in(raw_in), .glitch_clr(glitch_clr),
        .x_out(x_out), .rise(rise), .fall(fall), .glitch_cnt(glitch_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: raw samples and synchronized samples recorded since the last reset.
    bit raw_hist[$];
    bit s_hist[$];
    bit m_x, m_rise, m_fall;
    int m_glitch;

    task automatic model_edge(input bit r, input bit c, input bit rs);
        bit s;
        bit all_new;
        int n;
        if (rs) begin
            raw_hist.delete();
            s_hist.delete();
            m_x = 0; m_rise = 0; m_fall = 0; m_glitch = 0;
            return;
        end
        s = (raw_hist.size() >= N_SYNC) ? raw_hist[raw_hist.size() - N_SYNC] : 1'b0;
        raw_hist.push_back(r);
        s_hist.push_back(s);
        n = s_hist.size();
        m_rise = 0;
        m_fall = 0;
        all_new = (n >= N_DEB);
        for (int k = 0; k < N_DEB && k < n; k++) begin
            if (s_hist[n - 1 - k] == m_x) all_new = 0;
        end
        if (all_new) begin
            m_x = ~m_x;
            if (m_x) m_rise = 1; else m_fall = 1;
        end
        if (c) begin
            m_glitch = 0;
        end else if (!all_new && s == m_x && n >= 2 && s_hist[n - 2] != m_x) begin
            if (m_glitch < GMAX) m_glitch++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, apply the edge to the model, compare on the falling edge.
    task automatic tick(input bit r, input bit c, input bit rs);
        raw_in = r; glitch_clr = c; reset = rs;
        @(posedge clock);
        model_edge(r, c, rs);
        @(negedge clock);
        check("model_x_out", x_out, m_x);
        check("model_rise", rise, m_rise);
        check("model_fall", fall, m_fall);
        check("model_glitch_cnt", glitch_cnt, m_glitch);
        if (rise && fall) check("rise_fall_exclusive", 1, 0);
    endtask

    typedef struct {
        bit raw, clr, rst;
        bit ex, er, ef;
        int eg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit raw, clr, rst, ex, er, ef, input int eg);
        vec_t v;
        v.raw = raw; v.clr = clr; v.rst = rst; v.ex = ex; v.er = er; v.ef = ef; v.eg = eg;
        vecs.push_back(v);
    endtask

    initial begin
        int rises, edge_at, base_g, run_len;
        bit lvl;

        // Reset held with raw high, then rise, fall, a glitch, and clear-vs-glitch.
        repeat (3) add(1, 0, 1, 0, 0, 0, 0);
        repeat (5) add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        repeat (5) add(0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            tick(vecs[i].raw, vecs[i].clr, vecs[i].rst);
            check($sformatf("vec%0d_x_out", i), x_out, vecs[i].ex);
            check($sformatf("vec%0d_rise", i), rise, vecs[i].er);
            check($sformatf("vec%0d_fall", i), fall, vecs[i].ef);
            check($sformatf("vec%0d_glitch", i), glitch_cnt, vecs[i].eg);
        end

        // Repeated short pulses: counter saturates without wrapping.
        for (int i = 0; i < 300; i++) begin
            tick(1, 0, 0); tick(1, 0, 0);
            tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        end
        check("saturate_glitch_cnt", glitch_cnt, 255);
        check("saturate_x_out", x_out, 0);

        // Bounce 1,0,1,0,1 then hold: one rise, 5 edges after the final low-to-high.
        tick(0, 1, 0);
        tick(0, 0, 0);
        tick(1, 0, 0); tick(0, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
        rises = 0; edge_at = -1;
        for (int e = 0; e < 12; e++) begin
            tick(1, 0, 0);
            if (rise) rises++;
            if (x_out && edge_at < 0) edge_at = e;
        end
        check("bounce_rise_edge", edge_at, 5);
        check("bounce_rise_count", rises, 1);
        check("bounce_glitch_cnt", glitch_cnt, 2);

        // Fall from a stable high level.
        edge_at = -1;
        for (int e = 0; e < 12; e++) begin
            tick(0, 0, 0);
            if (fall && edge_at < 0) edge_at = e;
        end
        check("fall_edge", edge_at, 5);
        check("fall_x_out", x_out, 0);

        // Reset while pending high at cnt=3: no rise, then full requalification.
        for (int e = 0; e < 5; e++) tick(1, 0, 0);
        check("pend_no_rise_yet", x_out, 0);
        tick(1, 0, 1);
        check("reset_mid_x_out", x_out, 0);
        check("reset_mid_rise", rise, 0);
        edge_at = -1;
        for (int e = 0; e < 12; e++) begin
            tick(1, 0, 0);
            if (x_out && edge_at < 0) edge_at = e;
        end
        check("requalify_edge", edge_at, 5);

        // Randomized bouncing input with occasional clears and resets.
        base_g = 0;
        lvl = 1;
        for (int i = 0; i < 600; i++) begin
            lvl = ~lvl;
            run_len = $urandom_range(1, 7);
            for (int k = 0; k < run_len; k++) begin
                tick(lvl, ($urandom_range(0, 63) == 0), ($urandom_range(0, 299) == 0));
                base_g++;
            end
        end
        check("random_ran", (base_g > 600) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
